alu_uart_sequencer: RTL

- Sits between the UART receiver/transmitter pair and the combinational ALU.
- Collects a three-byte command frame from the receiver (operand A, operand B, opcode) and drives those values onto the ALU inputs.
- Registers the ALU result and hands it to the transmitter with a start/done handshake.
- Validates the opcode and flags receiver overruns while a result is in flight.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_uart_sequencer.sv | 113 +++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its UART command sequencer.
//   - Opcode constants (MIPS-style funct codes) used by both the ALU and the sequencer.
//   - Sequencer FSM state enumeration.
//   - ERR_BYTE: byte returned to the host when an opcode is not recognised.
//   - op_is_valid(): opcode legality check.
package alu_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'h20;
    localparam logic [OP_W-1:0] OP_SUB = 6'h22;
    localparam logic [OP_W-1:0] OP_AND = 6'h24;
    localparam logic [OP_W-1:0] OP_OR  = 6'h25;
    localparam logic [OP_W-1:0] OP_XOR = 6'h26;
    localparam logic [OP_W-1:0] OP_NOR = 6'h27;
    localparam logic [OP_W-1:0] OP_SRA = 6'h03;
    localparam logic [OP_W-1:0] OP_SRL = 6'h02;

    localparam logic [7:0] ERR_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        StWaitA,
        StWaitB,
        StWaitOp,
        StExec,
        StSend,
        StWaitTx
    } seq_state_t;

    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: collects a three-byte command frame (A, B, opcode) from a UART
// receiver, presents it to an external combinational ALU, registers the result and
// hands it to a UART transmitter with a start/done handshake.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   rx_data, rx_done        received byte and its one-cycle valid pulse
//   alu_a, alu_b, alu_op    registered operands/opcode driven to the ALU
//   alu_result              combinational ALU result
//   tx_data, tx_start       byte to transmit and its one-cycle start pulse
//   tx_done                 one-cycle pulse, transmitter finished the byte
//   op_err                  one-cycle pulse, invalid opcode (tx_data = all ones)
//   overrun                 one-cycle pulse, received byte dropped while busy
module alu_uart_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned N_op = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    rx_data,
    input  logic            rx_done,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [N_op-1:0] alu_op,
    input  logic [N-1:0]    alu_result,
    output logic [N-1:0]    tx_data,
    output logic            tx_start,
    input  logic            tx_done,
    output logic            op_err,
    output logic            overrun
);

    seq_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StWaitA;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            op_err   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle below.
            tx_start <= 1'b0;
            op_err   <= 1'b0;
            overrun  <= 1'b0;

            case (state)
                StWaitA: begin
                    if (rx_done) begin
                        alu_a <= rx_data;
                        state <= StWaitB;
                    end
                end

                StWaitB: begin
                    if (rx_done) begin
                        alu_b <= rx_data;
                        state <= StWaitOp;
                    end
                end

                StWaitOp: begin
                    if (rx_done) begin
                        alu_op <= rx_data[N_op-1:0];
                        state  <= StExec;
                    end
                end

                StExec: begin
                    // ALU inputs have been stable for a full cycle; capture its result.
                    if (op_is_valid(OP_W'(alu_op))) begin
                        tx_data <= alu_result;
                    end else begin
                        // All-ones error byte, sized to N rather than fixed at ERR_BYTE width.
                        tx_data <= {N{1'b1}};
                        op_err  <= 1'b1;
                    end
                    tx_start <= 1'b1;
                    overrun  <= rx_done;
                    state    <= StSend;
                end

                StSend: begin
                    overrun <= rx_done;
                    state   <= StWaitTx;
                end

                StWaitTx: begin
                    if (tx_done) begin
                        // A byte arriving with tx_done starts the next frame immediately.
                        if (rx_done) begin
                            alu_a <= rx_data;
                            state <= StWaitB;
                        end else begin
                            state <= StWaitA;
                        end
                    end else begin
                        overrun <= rx_done;
                    end
                end

                default: state <= StWaitA;
            endcase
        end
    end

endmodule
